// File: rtl/trng_collector.sv
// Reader end of a ring-oscillator TRNG: synchronizes and samples the raw bit, applies
// von Neumann debiasing plus a repetition-count health test, and packs W-bit words.
module trng_collector #(
  parameter int W          = 32,
  parameter int SAMPLE_DIV = 64,
  parameter int WARMUP     = 16,
  parameter int RCT_CUTOFF = 32
) (
  input  logic         clk_in,
  input  logic         rst_,
  input  logic         en,
  input  logic         prn_in,
  output logic         ro_en,
  output logic [W-1:0] word_out,
  output logic         valid,
  input  logic         ready,
  output logic         health_fail
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int BIT_W  = $clog2(W);
  localparam int WARM_W = $clog2(WARMUP + 32'sd2);
  localparam int RCT_W  = $clog2(RCT_CUTOFF + 32'sd1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 32'sd1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W - 32'sd1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 32'sd0) ? (WARMUP - 32'sd1) : 32'sd0);
  localparam logic [RCT_W-1:0]  RCT_MAX   = RCT_W'(RCT_CUTOFF);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              sync1_r;
  logic              sync2_r;
  logic [DIV_W-1:0]  div_r;
  logic [WARM_W-1:0] warm_r;
  logic [RCT_W-1:0]  rct_cnt_r;
  logic              rct_prev_r;
  logic              pair_phase_r;
  logic              pair_first_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [W-1:0]      acc_r;
  logic [W-1:0]      word_r;
  logic              valid_r;
  logic              ro_en_r;
  logic              health_fail_r;

  logic              run_s;
  logic              run_nxt_s;
  logic              tick_s;
  logic              rct_active_s;
  logic [RCT_W-1:0]  rct_nxt_s;
  logic              rct_fail_s;
  logic              emit_s;
  logic              word_done_s;
  logic              warm_done_s;
  logic              in_ch_s;
  logic              nxt_ch_s;
  logic              keep_pair_s;
  logic              keep_bits_s;
  logic [W-1:0]      word_nxt_s;

  assign ro_en       = ro_en_r;
  assign word_out    = word_r;
  assign valid       = valid_r;
  assign health_fail = health_fail_r;

  // Two-flop synchronizer for the asynchronous raw TRNG bit.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= prn_in;
      sync2_r <= sync1_r;
    end
  end

  // Sample tick, health-test update and debias decode for the current cycle.
  always_comb begin
    run_s        = (state_r == ST_WARMUP) || (state_r == ST_COLLECT) || (state_r == ST_HOLD);
    in_ch_s      = (state_r == ST_COLLECT) || (state_r == ST_HOLD);
    tick_s       = run_s && (div_r == DIV_LAST);
    rct_active_s = tick_s && in_ch_s;
    // A zero count means no previous sample yet, so the run starts fresh.
    if ((rct_cnt_r == {RCT_W{1'b0}}) || (sync2_r != rct_prev_r)) begin
      rct_nxt_s = RCT_W'(1);
    end else if (rct_cnt_r < RCT_MAX) begin
      rct_nxt_s = rct_cnt_r + RCT_W'(1);
    end else begin
      rct_nxt_s = rct_cnt_r;
    end
    rct_fail_s  = rct_active_s && (rct_nxt_s == RCT_MAX);
    emit_s      = rct_active_s && pair_phase_r && (state_r == ST_COLLECT) && (pair_first_r != sync2_r);
    word_done_s = emit_s && (bit_cnt_r == BIT_LAST);
    warm_done_s = tick_s && (state_r == ST_WARMUP) && (warm_r == WARM_LAST);
    word_nxt_s  = acc_r;
    word_nxt_s[bit_cnt_r] = pair_first_r;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else if (WARMUP == 32'sd0) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else if (warm_done_s) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_COLLECT: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else if (rct_fail_s) begin
          state_nxt_s = ST_FAIL;
        end else if (word_done_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        // A handshake coinciding with a health failure still completes the transfer.
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else if (rct_fail_s) begin
          state_nxt_s = ST_FAIL;
        end else if (ready) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_FAIL: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FAIL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    run_nxt_s   = (state_nxt_s == ST_WARMUP) || (state_nxt_s == ST_COLLECT) || (state_nxt_s == ST_HOLD);
    nxt_ch_s    = (state_nxt_s == ST_COLLECT) || (state_nxt_s == ST_HOLD);
    keep_pair_s = in_ch_s && nxt_ch_s && !((state_r == ST_HOLD) && (state_nxt_s == ST_COLLECT));
    keep_bits_s = (state_r == ST_COLLECT) && (state_nxt_s == ST_COLLECT);
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Free-running sample divider; held at zero whenever sampling is stopped.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      div_r <= {DIV_W{1'b0}};
    end else if (run_s && run_nxt_s) begin
      div_r <= (div_r == DIV_LAST) ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
    end else begin
      div_r <= {DIV_W{1'b0}};
    end
  end

  // Warm-up tick counter.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      warm_r <= {WARM_W{1'b0}};
    end else if ((state_r == ST_WARMUP) && (state_nxt_s == ST_WARMUP)) begin
      if (tick_s) begin
        warm_r <= warm_r + WARM_W'(1);
      end
    end else begin
      warm_r <= {WARM_W{1'b0}};
    end
  end

  // Repetition-count state; cleared outside COLLECT/HOLD so the first collected sample restarts it.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      rct_cnt_r  <= {RCT_W{1'b0}};
      rct_prev_r <= 1'b0;
    end else if (in_ch_s && nxt_ch_s) begin
      if (rct_active_s) begin
        rct_cnt_r  <= rct_nxt_s;
        rct_prev_r <= sync2_r;
      end
    end else begin
      rct_cnt_r  <= {RCT_W{1'b0}};
      rct_prev_r <= 1'b0;
    end
  end

  // Von Neumann pair tracking.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      pair_phase_r <= 1'b0;
      pair_first_r <= 1'b0;
    end else if (keep_pair_s) begin
      if (rct_active_s) begin
        pair_phase_r <= ~pair_phase_r;
        pair_first_r <= sync2_r;
      end
    end else begin
      pair_phase_r <= 1'b0;
      pair_first_r <= 1'b0;
    end
  end

  // Partial-word accumulator, filled LSB first.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      acc_r     <= {W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
    end else if (keep_bits_s) begin
      if (emit_s) begin
        acc_r     <= word_nxt_s;
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
    end else begin
      acc_r     <= {W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
    end
  end

  // Registered outputs; word_out only changes when a complete word is delivered.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      word_r        <= {W{1'b0}};
      valid_r       <= 1'b0;
      ro_en_r       <= 1'b0;
      health_fail_r <= 1'b0;
    end else begin
      if ((state_r == ST_COLLECT) && (state_nxt_s == ST_HOLD)) begin
        word_r <= word_nxt_s;
      end
      valid_r       <= (state_nxt_s == ST_HOLD);
      ro_en_r       <= run_nxt_s;
      health_fail_r <= (state_nxt_s == ST_FAIL);
    end
  end

endmodule
